reg_file: RTL and testbench

Generic synchronous register file with one read port, one write port, a bulk clear and per-entry zero flags. Two instances form the ping-pong activation store inside each processing element. The activation wrapper swaps the roles of the two instances between layers and uses the zero flags to skip zero activations.

---
 rtl/reg_file_pkg.sv | 18 +
 rtl/reg_file_zero_det.sv | 14 +
 rtl/reg_file.sv | 86 ++++++++
 tb/tb_reg_file.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and the address-width helper for reg_file and its instantiators.
package reg_file_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int DEPTH      = 16;

  // Smallest width that can address `value` entries; a single entry still gets one bit.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    if (result == 0) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/reg_file_zero_det.sv
// Per-entry NOR-reduce: zeros_o[i] is high when entry i holds all-zero bits.
module reg_file_zero_det #(
  parameter int BIT_WIDTH = 16,
  parameter int REG_DEPTH = 16
) (
  input  logic [REG_DEPTH*BIT_WIDTH-1:0] entries_i,
  output logic [REG_DEPTH-1:0]           zeros_o
);

  for (genvar i = 0; i < REG_DEPTH; i++) begin : g_entry
    assign zeros_o[i] = ~|entries_i[i*BIT_WIDTH +: BIT_WIDTH];
  end

endmodule

// File: rtl/reg_file.sv
// One-read/one-write register file with bulk clear and per-entry zero flags.
// Define REG_FILE_BYPASS_EN to forward same-cycle writes (and clears) to the read port.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int  BIT_WIDTH = DATA_WIDTH,
  parameter int  REG_DEPTH = DEPTH,
  localparam int AW        = clog2(REG_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 read_en,
  input  logic [AW-1:0]        read_addr,
  output logic [BIT_WIDTH-1:0] read_data,
  input  logic                 write_en,
  input  logic [AW-1:0]        write_addr,
  input  logic [BIT_WIDTH-1:0] write_data,
  output logic [REG_DEPTH-1:0] zeros
);

  // One extra bit so the limit is representable when REG_DEPTH is a power of two.
  localparam logic [AW:0] ADDR_LIMIT = REG_DEPTH[AW:0];

  logic [BIT_WIDTH-1:0]           mem_q [REG_DEPTH];
  logic [BIT_WIDTH-1:0]           mem_d [REG_DEPTH];
  logic [BIT_WIDTH-1:0]           read_data_q;
  logic [BIT_WIDTH-1:0]           read_data_d;
  logic [BIT_WIDTH-1:0]           read_value;
  logic [REG_DEPTH*BIT_WIDTH-1:0] mem_flat;
  logic                           write_in_range;
  logic                           read_in_range;

  assign write_in_range = {1'b0, write_addr} < ADDR_LIMIT;
  assign read_in_range  = {1'b0, read_addr} < ADDR_LIMIT;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    mem_d = mem_q;
    if (clear) begin
      for (int i = 0; i < REG_DEPTH; i++) mem_d[i] = '0;
    end else if (write_en && write_in_range) begin
      mem_d[write_addr] = write_data;
    end
  end

  always_comb begin
    read_value = read_in_range ? mem_q[read_addr] : '0;
`ifdef REG_FILE_BYPASS_EN
    if (clear) begin
      read_value = '0;
    end else if (write_en && (write_addr == read_addr)) begin
      read_value = write_data;
    end
`endif
    read_data_d = read_en ? read_value : read_data_q;
  end

  // NOTE: the storage array is reset because the zero flags must read all-ones straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_DEPTH; i++) mem_q[i] <= '0;
      read_data_q <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
      mem_q       <= mem_d;
      read_data_q <= read_data_d;
    end
  end

  assign read_data = read_data_q;

  always_comb begin
    mem_flat = '0;
    for (int i = 0; i < REG_DEPTH; i++) mem_flat[i*BIT_WIDTH +: BIT_WIDTH] = mem_q[i];
  end

  reg_file_zero_det #(
    .BIT_WIDTH(BIT_WIDTH),
    .REG_DEPTH(REG_DEPTH)
  ) u_zero_det (
    .entries_i(mem_flat),
    .zeros_o  (zeros)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file at default size; collision expectations follow REG_FILE_BYPASS_EN.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        read_en;
  logic [3:0]  read_addr;
  logic [15:0] read_data;
  logic        write_en;
  logic [3:0]  write_addr;
  logic [15:0] write_data;
  logic [15:0] zeros;

  int errors;
  int checks;

  reg_file dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .read_en   (read_en),
    .read_addr (read_addr),
    .read_data (read_data),
    .write_en  (write_en),
    .write_addr(write_addr),
    .write_data(write_data),
    .zeros     (zeros)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled and inputs changed 1 time unit later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    clear      = 1'b0;
    read_en    = 1'b0;
    read_addr  = '0;
    write_en   = 1'b0;
    write_addr = '0;
    write_data = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (read_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_read_data got=%h exp=%h", read_data, 16'h0000);
    end
    checks++;
    if (zeros !== 16'hFFFF) begin
      errors++;
      $display("FAIL reset_zeros got=%h exp=%h", zeros, 16'hFFFF);
    end
    tick();
    rst_n     = 1'b1;
    read_en   = 1'b1;
    read_addr = 4'd5;
    tick();
    read_en = 1'b0;
    checks++;
    if (read_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_read5 got=%h exp=%h", read_data, 16'h0000);
    end
  endtask

  task automatic test_write_read;
    write_en   = 1'b1;
    write_addr = 4'd3;
    write_data = 16'h1234;
    tick();
    write_en = 1'b0;
    checks++;
    if (zeros !== 16'hFFF7) begin
      errors++;
      $display("FAIL wr_zeros got=%h exp=%h", zeros, 16'hFFF7);
    end
    read_en   = 1'b1;
    read_addr = 4'd3;
    tick();
    checks++;
    if (read_data !== 16'h1234) begin
      errors++;
      $display("FAIL wr_read3 got=%h exp=%h", read_data, 16'h1234);
    end
    read_en   = 1'b0;
    read_addr = 4'd0;
    tick();
    checks++;
    if (read_data !== 16'h1234) begin
      errors++;
      $display("FAIL wr_hold got=%h exp=%h", read_data, 16'h1234);
    end
  endtask

  task automatic test_clear_priority;
    logic [15:0] exp_clear_read;
    for (int i = 0; i < 16; i++) begin
      write_en   = 1'b1;
      write_addr = 4'(i);
      write_data = 16'(i + 1);
      tick();
    end
    write_en = 1'b0;
    checks++;
    if (zeros !== 16'h0000) begin
      errors++;
      $display("FAIL fill_zeros got=%h exp=%h", zeros, 16'h0000);
    end
    read_en   = 1'b1;
    read_addr = 4'd15;
    tick();
    checks++;
    if (read_data !== 16'h0010) begin
      errors++;
      $display("FAIL fill_read15 got=%h exp=%h", read_data, 16'h0010);
    end
    clear      = 1'b1;
    write_en   = 1'b1;
    write_addr = 4'd2;
    write_data = 16'hBEEF;
    read_addr  = 4'd4;
`ifdef REG_FILE_BYPASS_EN
    exp_clear_read = 16'h0000;
`else
    exp_clear_read = 16'h0005;
`endif
    tick();
    clear    = 1'b0;
    write_en = 1'b0;
    checks++;
    if (zeros !== 16'hFFFF) begin
      errors++;
      $display("FAIL clear_zeros got=%h exp=%h", zeros, 16'hFFFF);
    end
    checks++;
    if (read_data !== exp_clear_read) begin
      errors++;
      $display("FAIL clear_read4 got=%h exp=%h", read_data, exp_clear_read);
    end
    read_addr = 4'd2;
    tick();
    read_en = 1'b0;
    checks++;
    if (read_data !== 16'h0000) begin
      errors++;
      $display("FAIL clear_read2 got=%h exp=%h", read_data, 16'h0000);
    end
  endtask

  task automatic test_collision;
    logic [15:0] exp_collide;
    write_en   = 1'b1;
    write_addr = 4'd7;
    write_data = 16'h0055;
    tick();
    write_data = 16'h00AA;
    read_en    = 1'b1;
    read_addr  = 4'd7;
`ifdef REG_FILE_BYPASS_EN
    exp_collide = 16'h00AA;
`else
    exp_collide = 16'h0055;
`endif
    tick();
    write_en = 1'b0;
    checks++;
    if (read_data !== exp_collide) begin
      errors++;
      $display("FAIL collide_read got=%h exp=%h", read_data, exp_collide);
    end
    checks++;
    if (zeros !== 16'hFF7F) begin
      errors++;
      $display("FAIL collide_zeros got=%h exp=%h", zeros, 16'hFF7F);
    end
    tick();
    read_en = 1'b0;
    checks++;
    if (read_data !== 16'h00AA) begin
      errors++;
      $display("FAIL collide_reread got=%h exp=%h", read_data, 16'h00AA);
    end
  endtask

  task automatic test_zero_write;
    write_en   = 1'b1;
    write_addr = 4'd9;
    write_data = 16'h0009;
    tick();
    checks++;
    if (zeros !== 16'hFD7F) begin
      errors++;
      $display("FAIL zw_nonzero got=%h exp=%h", zeros, 16'hFD7F);
    end
    write_data = 16'h0000;
    tick();
    write_en = 1'b0;
    checks++;
    if (zeros !== 16'hFF7F) begin
      errors++;
      $display("FAIL zw_zero got=%h exp=%h", zeros, 16'hFF7F);
    end
  endtask

  task automatic test_back_to_back_reset;
    read_en    = 1'b1;
    read_addr  = 4'd7;
    write_en   = 1'b1;
    write_addr = 4'd0;
    write_data = 16'h00A0;
    tick();
    write_addr = 4'd1;
    write_data = 16'h00A1;
    tick();
    checks++;
    if (read_data !== 16'h00AA) begin
      errors++;
      $display("FAIL b2b_pre_read got=%h exp=%h", read_data, 16'h00AA);
    end
    write_addr = 4'd2;
    write_data = 16'h00A2;
    read_en    = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (read_data !== 16'h0000) begin
      errors++;
      $display("FAIL b2b_rst_read got=%h exp=%h", read_data, 16'h0000);
    end
    checks++;
    if (zeros !== 16'hFFFF) begin
      errors++;
      $display("FAIL b2b_rst_zeros got=%h exp=%h", zeros, 16'hFFFF);
    end
    #1 rst_n = 1'b1;
    tick();
    write_en = 1'b0;
    checks++;
    if (zeros !== 16'hFFFB) begin
      errors++;
      $display("FAIL b2b_post_zeros got=%h exp=%h", zeros, 16'hFFFB);
    end
    read_en   = 1'b1;
    read_addr = 4'd2;
    tick();
    checks++;
    if (read_data !== 16'h00A2) begin
      errors++;
      $display("FAIL b2b_read2 got=%h exp=%h", read_data, 16'h00A2);
    end
    read_addr = 4'd0;
    tick();
    read_en = 1'b0;
    checks++;
    if (read_data !== 16'h0000) begin
      errors++;
      $display("FAIL b2b_read0 got=%h exp=%h", read_data, 16'h0000);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_write_read();
    test_clear_priority();
    test_collision();
    test_zero_write();
    test_back_to_back_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
